// File: rtl/vector_issue_unit.sv
// Instruction sequencer and four-entry 512-bit vector register file feeding the 16-lane ALU.
// Load/store moves whole registers to/from memory; add/multiply writes the split 64-bit lane results into A3/A4.
module vector_issue_unit #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [1:0]        instr_op,
    input  logic [1:0]        instr_reg,
    input  logic [ADDR_W-1:0] instr_addr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [511:0]      mem_wdata,
    input  logic [511:0]      mem_rdata,
    input  logic              mem_ack,
    output logic [511:0]      alu_op1,
    output logic [511:0]      alu_op2,
    output logic [1:0]        alu_op,
    input  logic [1023:0]     alu_result,
    output logic              done,
    output logic              err,
    input  logic [1:0]        dbg_sel,
    output logic [511:0]      dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        MEM  = 2'b10
    } state_t;

    // The wait counter counts unacknowledged MEM edges; the edge that would make it TIMEOUT aborts.
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t       state_r;
    state_t       state_s;
    logic [511:0] vreg_r [4];
    logic [1:0]   reg_r;
    logic [7:0]   cnt_r;
    logic         accept_s;
    logic         mem_done_s;
    logic         timeout_s;
    logic         alu_wb_s;
    logic [511:0] lo_s;
    logic [511:0] hi_s;

    assign instr_ready = (state_r == IDLE) && !rst;
    assign alu_op1     = vreg_r[0];
    assign alu_op2     = vreg_r[1];
    assign dbg_data    = vreg_r[dbg_sel];

    // Next-state decode and single-cycle event strobes
    always_comb begin
        state_s    = state_r;
        accept_s   = 1'b0;
        mem_done_s = 1'b0;
        timeout_s  = 1'b0;
        alu_wb_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (instr_valid && instr_ready) begin
                    accept_s = 1'b1;
                    state_s  = instr_op[1] ? EXEC : MEM;
                end else begin
                    state_s = IDLE;
                end
            end
            EXEC: begin
                alu_wb_s = 1'b1;
                state_s  = IDLE;
            end
            MEM: begin
                // An ack on the timeout edge still completes the access.
                if (mem_ack) begin
                    mem_done_s = 1'b1;
                    state_s    = IDLE;
                end else if (cnt_r == LAST_WAIT) begin
                    timeout_s = 1'b1;
                    state_s   = IDLE;
                end else begin
                    state_s = MEM;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Split each 64-bit ALU lane into its low word (A3) and high word (A4)
    always_comb begin
        lo_s = '0;
        hi_s = '0;
        for (int i = 0; i < 16; i++) begin
            lo_s[32*i +: 32] = alu_result[64*i +: 32];
            hi_s[32*i +: 32] = alu_result[64*i+32 +: 32];
        end
    end

    // Control state, memory request and completion pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            reg_r     <= 2'b00;
            cnt_r     <= 8'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            alu_op    <= 2'b00;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_r <= state_s;
            done    <= mem_done_s | alu_wb_s;
            err     <= timeout_s;
            if (accept_s) begin
                reg_r <= instr_reg;
                cnt_r <= 8'd0;
                if (instr_op[1]) begin
                    alu_op <= instr_op;
                end else begin
                    mem_req   <= 1'b1;
                    mem_we    <= ~instr_op[0];
                    mem_addr  <= instr_addr;
                    mem_wdata <= vreg_r[instr_reg];
                end
            end else if (mem_done_s || timeout_s) begin
                mem_req <= 1'b0;
            end else if (state_r == MEM) begin
                cnt_r <= cnt_r + 8'd1;
            end else if (alu_wb_s) begin
                alu_op <= 2'b00;
            end
        end
    end

    // Vector register file: loads write any register, ALU writeback updates A3/A4
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                vreg_r[i] <= '0;
            end
        end else if (mem_done_s && !mem_we) begin
            vreg_r[reg_r] <= mem_rdata;
        end else if (alu_wb_s) begin
            vreg_r[2] <= lo_s;
            vreg_r[3] <= hi_s;
        end
    end

endmodule

// File: tb/tb_vector_issue_unit.sv
// Directed bench for vector_issue_unit: table-driven ALU vectors plus hand-written memory,
// timeout, handshake and reset sequences. Inputs change and outputs are sampled on the falling edge.
module tb_vector_issue_unit;

    localparam int ADDR_W = 16;
    localparam int TO     = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              instr_valid = 1'b0;
    logic              instr_ready;
    logic [1:0]        instr_op = 2'b00;
    logic [1:0]        instr_reg = 2'b00;
    logic [ADDR_W-1:0] instr_addr = '0;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [511:0]      mem_wdata;
    logic [511:0]      mem_rdata = '0;
    logic              mem_ack = 1'b0;
    logic [511:0]      alu_op1;
    logic [511:0]      alu_op2;
    logic [1:0]        alu_op;
    logic [1023:0]     alu_result;
    logic              done;
    logic              err;
    logic [1:0]        dbg_sel = 2'b00;
    logic [511:0]      dbg_data;

    int errors = 0;
    int checks = 0;

    logic [511:0] exp_reg [4];
    logic [511:0] garbage;
    logic [511:0] pat;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
    } alu_vec_t;

    alu_vec_t vecs [6];

    always #5 clk = ~clk;

    vector_issue_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_reg(instr_reg), .instr_addr(instr_addr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_op(alu_op),
        .alu_result(alu_result), .done(done), .err(err),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    function automatic logic [63:0] sx(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Signed 16-lane ALU; an idle opcode yields a poison pattern
    always_comb begin
        alu_result = '0;
        for (int i = 0; i < 16; i++) begin
            case (alu_op)
                2'b10:   alu_result[64*i +: 64] = sx(alu_op1[32*i +: 32]) + sx(alu_op2[32*i +: 32]);
                2'b11:   alu_result[64*i +: 64] = sx(alu_op1[32*i +: 32]) * sx(alu_op2[32*i +: 32]);
                default: alu_result[64*i +: 64] = 64'hDEAD_BEEF_0BAD_F00D;
            endcase
        end
    end

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reg(input int idx, input logic [511:0] exp, input string name);
        dbg_sel = 2'(idx);
        #1;
        check(name, dbg_data, exp);
    endtask

    task automatic check_all_regs(input string name);
        for (int r = 0; r < 4; r++) begin
            check_reg(r, exp_reg[r], $sformatf("%s_a%0d", name, r + 1));
        end
    endtask

    // Present one instruction at a falling edge; returns at the falling edge after the accept edge
    task automatic issue(input logic [1:0] op, input logic [1:0] r, input logic [15:0] addr);
        instr_valid = 1'b1;
        instr_op    = op;
        instr_reg   = r;
        instr_addr  = addr;
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic do_load(input logic [1:0] r, input logic [511:0] d, input int waits, input string name);
        logic [15:0] addr;
        addr = 16'h0100 + 16'(r);
        issue(2'b01, r, addr);
        check({name, "_req"}, mem_req, 1'b1);
        check({name, "_we"}, mem_we, 1'b0);
        check({name, "_addr"}, mem_addr, addr);
        for (int k = 0; k < waits; k++) begin
            @(negedge clk);
            check({name, "_hold"}, {mem_req, done, err}, 3'b100);
        end
        mem_ack   = 1'b1;
        mem_rdata = d;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = garbage;
        check({name, "_done"}, {done, err, mem_req, instr_ready}, 4'b1001);
        exp_reg[r] = d;
        check_reg(r, d, {name, "_data"});
        @(negedge clk);
        check({name, "_pulse"}, done, 1'b0);
    endtask

    task automatic do_alu(input logic [1:0] op, input logic [31:0] lo, input logic [31:0] hi, input string name);
        issue(op, 2'b00, 16'h0000);
        check({name, "_aluop"}, alu_op, op);
        check({name, "_busy"}, {done, instr_ready}, 2'b00);
        @(negedge clk);
        check({name, "_done"}, {done, err, instr_ready, alu_op}, 5'b10100);
        exp_reg[2] = {16{lo}};
        exp_reg[3] = {16{hi}};
        check_reg(2, exp_reg[2], {name, "_a3"});
        check_reg(3, exp_reg[3], {name, "_a4"});
        @(negedge clk);
        check({name, "_pulse"}, done, 1'b0);
    endtask

    initial begin
        vecs[0] = '{op: 2'b10, a: 32'h0000_0005, b: 32'h0000_0003, lo: 32'h0000_0008, hi: 32'h0000_0000};
        vecs[1] = '{op: 2'b11, a: 32'h0000_0005, b: 32'hFFFF_FFFD, lo: 32'hFFFF_FFF1, hi: 32'hFFFF_FFFF};
        vecs[2] = '{op: 2'b10, a: 32'hFFFF_FFFF, b: 32'h0000_0001, lo: 32'h0000_0000, hi: 32'h0000_0000};
        vecs[3] = '{op: 2'b11, a: 32'h0001_0000, b: 32'h0001_0000, lo: 32'h0000_0000, hi: 32'h0000_0001};
        vecs[4] = '{op: 2'b10, a: 32'h7FFF_FFFF, b: 32'h7FFF_FFFF, lo: 32'hFFFF_FFFE, hi: 32'h0000_0000};
        vecs[5] = '{op: 2'b11, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, lo: 32'h0000_0001, hi: 32'h0000_0000};
        for (int r = 0; r < 4; r++) exp_reg[r] = '0;
        garbage = {16{32'hA5A5_5A5A}};
        for (int i = 0; i < 16; i++) pat[32*i +: 32] = 32'h1000_0000 + 32'(i * 17);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", instr_ready, 1'b0);
        check("rst_ctrl", {mem_req, mem_we, done, err, alu_op}, 6'b000000);
        check("rst_addr", mem_addr, 16'h0000);
        check("rst_wdata", mem_wdata, 512'h0);
        check_all_regs("rst");
        rst = 1'b0;
        #1;
        check("rel_ready", instr_ready, 1'b1);
        @(negedge clk);

        // Table-driven ALU vectors
        for (int i = 0; i < 6; i++) begin
            do_load(2'd0, {16{vecs[i].a}}, i % 3, $sformatf("v%0d_lda1", i));
            do_load(2'd1, {16{vecs[i].b}}, 2, $sformatf("v%0d_lda2", i));
            do_alu(vecs[i].op, vecs[i].lo, vecs[i].hi, $sformatf("v%0d", i));
            check_all_regs($sformatf("v%0d_after", i));
        end

        // Per-lane data through a load, then store A3
        do_load(2'd2, pat, 1, "ld_pat");
        issue(2'b00, 2'd2, 16'h0040);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("st_hold%0d", k), {mem_req, mem_we, done, err}, 4'b1100);
            check($sformatf("st_addr%0d", k), mem_addr, 16'h0040);
            check($sformatf("st_wdata%0d", k), mem_wdata, pat);
        end
        mem_ack   = 1'b1;
        mem_rdata = garbage;
        @(negedge clk);
        mem_ack = 1'b0;
        check("st_done", {done, err, mem_req}, 3'b100);
        check_all_regs("st_regs");

        // Stray ack while idle
        mem_ack = 1'b1;
        @(negedge clk);
        check("stray_ack0", {done, err, mem_req}, 3'b000);
        @(negedge clk);
        mem_ack = 1'b0;
        check("stray_ack1", {done, err, mem_req}, 3'b000);
        check_all_regs("stray");

        // Timeout: err exactly TO cycles after mem_req rises
        issue(2'b01, 2'd1, 16'h0200);
        check("to_req", mem_req, 1'b1);
        for (int k = 1; k < TO; k++) begin
            @(negedge clk);
            check($sformatf("to_wait%0d", k), {mem_req, done, err}, 3'b100);
        end
        @(negedge clk);
        check("to_err", {err, done, mem_req, instr_ready}, 4'b1001);
        @(negedge clk);
        check("to_pulse", err, 1'b0);
        check_all_regs("to_regs");

        // Ack on the timeout edge wins
        issue(2'b01, 2'd0, 16'h0210);
        for (int k = 1; k < TO; k++) begin
            @(negedge clk);
            check($sformatf("race_wait%0d", k), {mem_req, done, err}, 3'b100);
        end
        mem_ack   = 1'b1;
        mem_rdata = {16{32'h0000_0007}};
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = garbage;
        check("race_done", {done, err}, 2'b10);
        exp_reg[0] = {16{32'h0000_0007}};
        check_reg(0, exp_reg[0], "race_a1");
        @(negedge clk);

        // instr_valid held through an ALU op: next accept two edges later
        do_load(2'd1, {16{32'hFFFF_FFFF}}, 0, "hs_lda2");
        instr_valid = 1'b1;
        instr_op    = 2'b10;
        @(negedge clk);
        check("hs_first", {alu_op, instr_ready}, 3'b100);
        instr_op = 2'b11;
        @(negedge clk);
        check("hs_done1", {done, instr_ready, alu_op}, 4'b1100);
        check_reg(2, {16{32'h0000_0006}}, "hs_add_a3");
        check_reg(3, 512'h0, "hs_add_a4");
        @(negedge clk);
        instr_valid = 1'b0;
        check("hs_second", {alu_op, done, instr_ready}, 4'b1100);
        @(negedge clk);
        check("hs_done2", done, 1'b1);
        exp_reg[2] = {16{32'hFFFF_FFF9}};
        exp_reg[3] = {16{32'hFFFF_FFFF}};
        check_all_regs("hs_mul");
        @(negedge clk);

        // Reset in the middle of a load
        issue(2'b01, 2'd3, 16'h0300);
        @(negedge clk);
        check("mrst_req", mem_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("mrst_async", {mem_req, instr_ready}, 2'b00);
        @(negedge clk);
        check("mrst_hold", {instr_ready, done, err, mem_req}, 4'b0000);
        rst = 1'b0;
        for (int r = 0; r < 4; r++) exp_reg[r] = '0;
        check_all_regs("mrst");
        check("mrst_state", {instr_ready, alu_op, mem_addr}, {1'b1, 2'b00, 16'h0000});
        @(negedge clk);
        check("mrst_quiet", {done, err, mem_req}, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vector_issue_unit.md
# vector_issue_unit

Sequencer and vector register file that sits directly upstream of the 16-lane ArithmeticLogicUnit. It accepts one instruction at a time over a valid/ready handshake and executes it in one of two ways:
- **Load/store:** moves 512-bit vectors between memory and four vector registers A1..A4.
- **Add/multiply:** drives A1/A2 and the opcode into the ALU, then splits the ALU's 1024-bit result (16 × 64-bit lanes) into low halves (to A3) and high halves (to A4).

## Interface
Parameters:
- ADDR_W, 16, memory address width
- TIMEOUT, 255, maximum cycles spent waiting for mem_ack before abort (1..255)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- instr_valid  in  1  instruction present
- instr_ready  out  1  unit can accept (state IDLE and rst low)
- instr_op  in  2  00 store, 01 load, 10 add, 11 multiply
- instr_reg  in  2  load/store register index: 0=A1, 1=A2, 2=A3, 3=A4
- instr_addr  in  ADDR_W  load/store memory address
- mem_req  out  1  registered memory request
- mem_we  out  1  1=write (store), 0=read (load); valid while mem_req
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  512  store data
- mem_rdata  in  512  load data, sampled on the edge where mem_ack is high
- mem_ack  in  1  memory completion
- alu_op1  out  512  always equal to A1
- alu_op2  out  512  always equal to A2
- alu_op  out  2  registered opcode of the current ALU instruction, 00 when not executing
- alu_result  in  1024  ALU output, lane i at bits [64i+63:64i]
- done  out  1  one-cycle pulse on successful completion
- err  out  1  one-cycle pulse on memory timeout
- dbg_sel  in  2  debug register select
- dbg_data  out  512  combinational read of the selected register

## Operation
- **States:** IDLE, EXEC, MEM.
- **Accept:** an instruction is accepted on a rising edge where instr_valid && instr_ready. instr_op, instr_reg and instr_addr are captured at that edge.
- **IDLE → EXEC** (op 10/11):
  - alu_op is set to the captured op.
  - At the end of the EXEC cycle, for each lane i=0..15:
    - A3[32i+31:32i] ← alu_result[64i+31:64i]
    - A4[32i+31:32i] ← alu_result[64i+63:64i+32]
  - Then → IDLE, done=1 for one cycle, alu_op ← 00.
- **IDLE → MEM** (op 00/01):
  - mem_req=1, mem_addr=instr_addr, mem_we=(op==00).
  - mem_wdata is the selected register, latched at accept.
  - mem_req is held until an edge with mem_ack=1.
  - On that edge: a load writes mem_rdata into the selected register; a store writes no register. Then → IDLE with mem_req=0 and done=1.
- **Timeout:** an 8-bit wait counter is cleared on entry to MEM and increments each MEM cycle without ack. When the counter reaches TIMEOUT with no ack: → IDLE, mem_req=0, err=1, no register write, no done.
- mem_ack outside MEM is ignored.
- Instructions with instr_valid low, or presented while instr_ready is low, are not captured. The upstream side holds the instruction until it is accepted.
- A1/A2 change only through loads. A3/A4 change through loads and ALU writeback.

## Timing
- **Reset values:** state IDLE; A1..A4, counter, mem_addr, mem_wdata all zero; mem_req, mem_we, done, err all 0; alu_op=00.
- instr_ready=0 while rst is high.
- **Reset mid-operation:** returns to IDLE asynchronously. mem_req drops immediately. No done/err pulse and no register write for the aborted instruction.
- **ALU latency:** accept at edge E0 → EXEC in cycle E0–E1 → A3/A4 updated at E1 → done high in cycle E1–E2, with instr_ready high in the same cycle. The earliest next accept is E2.
- **Back-to-back ALU instructions:** one completes every 2 cycles.
- **Memory:** mem_req rises in the cycle after accept.
  - If ack arrives on the first edge of MEM: completion edge = E1, done in cycle E1–E2.
  - Otherwise completion is on the first edge with ack.
- **Simultaneous ack and timeout:** on the same edge, ack wins. The unit signals done, and err stays 0.
- done and err are never high together.
- dbg_data is combinational and reflects a register write in the cycle after the writing edge.

## Test plan
- **Reset:** reset asserted mid-MEM with mem_req=1 → mem_req=0 without a clock edge. After release, dbg_data=0 for all four registers and no done/err.
- **Load then add:**
  - Stimulus: load A1 with all lanes 5 and A2 with all lanes 3 (ack after 2 cycles), then issue op 10.
  - Required: done 2 cycles after accept; A3 lanes = 0x00000008; A4 lanes = 0x00000000.
- **Multiply:**
  - Stimulus: A1 lanes = 5, A2 lanes = 0xFFFFFFFD (−3), op 11.
  - Required: A3 lanes = 0xFFFFFFF1; A4 lanes = 0xFFFFFFFF.
- **Store:**
  - Stimulus: store A3 to address 0x0040.
  - Required: mem_we=1, mem_addr=0x0040 and mem_wdata=A3, all held until ack; then done pulse, no register change.
- **Timeout:** load with TIMEOUT=4 and no ack → err pulse exactly 4 cycles after mem_req rises, target register unchanged, instr_ready=1 afterwards.
- **Handshake:** instr_valid held high through an ALU instruction → second instruction accepted exactly 2 edges after the first. Ack coinciding with the timeout edge → done=1, err=0.
